// File: rtl/ultrasonic_scanner.sv
// Round-robin HC-SR04 ranging engine: a single shared FSM fires one sensor at a time,
// times its echo in microseconds and publishes a hysteretic zone code per channel.
module ultrasonic_scanner #(
  parameter int unsigned N_CH       = 2,
  parameter int unsigned US_DIV     = 50,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 25000,
  parameter int unsigned GAP_US     = 60000,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned THR_NEAR   = 1160,
  parameter int unsigned THR_FAR    = 2320,
  parameter int unsigned HYST_US    = 58
) (
  input  logic                  clk50,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [N_CH-1:0]       echo,
  output logic [N_CH-1:0]       trig,
  output logic [N_CH*CNT_W-1:0] dist_us,
  output logic [N_CH*2-1:0]     zone,
  output logic [N_CH-1:0]       valid,
  output logic [N_CH-1:0]       timeout,
  output logic [2:0]            active_ch,
  output logic                  busy
);

  localparam int unsigned DIV_W    = (US_DIV > 1) ? $clog2(US_DIV) : 1;
  localparam int unsigned CNT_MAX  = (1 << CNT_W) - 1;
  localparam int unsigned MEAS_LIM = (TIMEOUT_US < CNT_MAX) ? TIMEOUT_US : CNT_MAX;
  localparam int unsigned MAX_A    = (TIMEOUT_US > GAP_US) ? TIMEOUT_US : GAP_US;
  localparam int unsigned MAX_US   = (MAX_A > TRIG_US) ? MAX_A : TRIG_US;
  localparam int unsigned US_W     = $clog2(MAX_US + 1);

  localparam logic [1:0] ZoneNear = 2'b01;
  localparam logic [1:0] ZoneMid  = 2'b10;
  localparam logic [1:0] ZoneFar  = 2'b00;

  typedef enum logic [2:0] {StIdle, StTrig, StWait, StMeas, StGap} state_e;

  state_e                state_q, state_d;
  logic [N_CH-1:0]       echo_meta_q, echo_sync_q;
  logic                  echo_sel, echo_prev_q, rise;
  logic [DIV_W-1:0]      div_q;
  logic                  tick;
  logic [US_W-1:0]       us_q, us_now;
  logic [2:0]            ch_q, ch_d;
  logic                  done_ok, done_to;
  logic [CNT_W-1:0]      meas;
  logic [1:0]            zone_prev, zone_new;
  logic [N_CH-1:0]       trig_d;
  logic [N_CH-1:0]       trig_q, valid_q, to_q;
  logic [N_CH*CNT_W-1:0] dist_q;
  logic [N_CH*2-1:0]     zone_q;

  assign tick   = (div_q == DIV_W'(US_DIV - 1));
  // Include this cycle's tick so a fall coinciding with a tick is counted.
  assign us_now = us_q + US_W'(tick);
  assign meas   = CNT_W'(us_now);
  assign rise   = echo_sel & ~echo_prev_q;

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      echo_meta_q <= '0;
      echo_sync_q <= '0;
      echo_prev_q <= 1'b0;
    end else begin
      echo_meta_q <= echo;
      echo_sync_q <= echo_meta_q;
      echo_prev_q <= echo_sel;
    end
  end

  // State register
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ch_q    <= 3'd0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    done_ok = 1'b0;
    done_to = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StTrig;
      end
      StTrig: begin
        if (tick && us_q == US_W'(TRIG_US - 1)) state_d = StWait;
      end
      StWait: begin
        if (rise) begin
          state_d = StMeas;
        end else if (tick && us_q == US_W'(TIMEOUT_US - 1)) begin
          done_to = 1'b1;
          state_d = StGap;
        end
      end
      StMeas: begin
        // A fall wins over a simultaneous limit hit.
        if (!echo_sel) begin
          done_ok = 1'b1;
          state_d = StGap;
        end else if (tick && us_q == US_W'(MEAS_LIM - 1)) begin
          done_to = 1'b1;
          state_d = StGap;
        end
      end
      StGap: begin
        if (tick && us_q == US_W'(GAP_US - 1)) begin
          state_d = enable ? StTrig : StIdle;
          ch_d    = (ch_q == 3'(N_CH - 1)) ? 3'd0 : ch_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and result decode
  always_comb begin
    busy      = (state_q != StIdle);
    echo_sel  = 1'b0;
    zone_prev = ZoneFar;
    trig_d    = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_q == 3'(k)) begin
        echo_sel  = echo_sync_q[k];
        zone_prev = zone_q[2*k +: 2];
      end
      if (state_d == StTrig && ch_d == 3'(k)) trig_d[k] = 1'b1;
    end

    zone_new = zone_prev;
    unique case (zone_prev)
      ZoneNear: begin
        if (32'(meas) >= THR_FAR + HYST_US)       zone_new = ZoneFar;
        else if (32'(meas) >= THR_NEAR + HYST_US) zone_new = ZoneMid;
      end
      ZoneMid: begin
        if (32'(meas) < THR_NEAR - HYST_US)       zone_new = ZoneNear;
        else if (32'(meas) >= THR_FAR + HYST_US)  zone_new = ZoneFar;
      end
      default: begin
        if (32'(meas) < THR_NEAR - HYST_US)       zone_new = ZoneNear;
        else if (32'(meas) < THR_FAR - HYST_US)   zone_new = ZoneMid;
        else                                      zone_new = ZoneFar;
      end
    endcase
  end

  // Prescaler and microsecond counter restart on every state change.
  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      us_q  <= '0;
    end else if (state_d != state_q) begin
      div_q <= '0;
      us_q  <= '0;
    end else begin
      div_q <= tick ? '0 : div_q + 1'b1;
      us_q  <= us_now;
    end
  end

  always_ff @(posedge clk50 or posedge reset) begin
    if (reset) begin
      trig_q  <= '0;
      valid_q <= '0;
      to_q    <= '0;
      dist_q  <= '0;
      zone_q  <= '0;
    end else begin
      trig_q  <= trig_d;
      valid_q <= '0;
      to_q    <= '0;
      for (int k = 0; k < N_CH; k++) begin
        if ((done_ok || done_to) && ch_q == 3'(k)) begin
          valid_q[k]               <= 1'b1;
          to_q[k]                  <= done_to;
          dist_q[k*CNT_W +: CNT_W] <= done_to ? {CNT_W{1'b1}} : meas;
          zone_q[2*k +: 2]         <= done_to ? ZoneFar : zone_new;
        end
      end
    end
  end

  assign trig      = trig_q;
  assign valid     = valid_q;
  assign timeout   = to_q;
  assign dist_us   = dist_q;
  assign zone      = zone_q;
  assign active_ch = ch_q;

endmodule

// File: tb/tb_ultrasonic_scanner.sv
// Bench for ultrasonic_scanner: directed and random echo pulses on a scaled-down
// configuration, checked against a microsecond-level model of ranging and hysteresis.
module tb_ultrasonic_scanner;

  localparam int unsigned N_CH    = 2;
  localparam int unsigned D       = 4;
  localparam int unsigned TRIG_US = 3;
  localparam int unsigned TO_US   = 300;
  localparam int unsigned GAP_US  = 20;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TN      = 40;
  localparam int unsigned TF      = 80;
  localparam int unsigned HY      = 4;

  logic                  clk50 = 1'b0;
  logic                  reset;
  logic                  enable;
  logic [N_CH-1:0]       echo;
  logic [N_CH-1:0]       trig;
  logic [N_CH*CNT_W-1:0] dist_us;
  logic [N_CH*2-1:0]     zone;
  logic [N_CH-1:0]       valid;
  logic [N_CH-1:0]       timeout;
  logic [2:0]            active_ch;
  logic                  busy;

  int         total = 0;
  int         bad   = 0;
  int         exp_ch;
  logic [1:0] mz [N_CH];

  ultrasonic_scanner #(
    .N_CH(N_CH), .US_DIV(D), .TRIG_US(TRIG_US), .TIMEOUT_US(TO_US), .GAP_US(GAP_US),
    .CNT_W(CNT_W), .THR_NEAR(TN), .THR_FAR(TF), .HYST_US(HY)
  ) dut (
    .clk50(clk50), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
    .dist_us(dist_us), .zone(zone), .valid(valid), .timeout(timeout),
    .active_ch(active_ch), .busy(busy)
  );

  always #5 clk50 = ~clk50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Zone rules: 01 near, 10 mid, 00 far, with a HY-wide dead band around each threshold.
  function automatic logic [1:0] ref_zone(input logic [1:0] z, input int d);
    if (z == 2'b01) begin
      if (d >= TF + HY) return 2'b00;
      if (d >= TN + HY) return 2'b10;
      return 2'b01;
    end
    if (z == 2'b10) begin
      if (d < TN - HY)  return 2'b01;
      if (d >= TF + HY) return 2'b00;
      return 2'b10;
    end
    if (d < TN - HY) return 2'b01;
    if (d < TF - HY) return 2'b10;
    return 2'b00;
  endfunction

  // kind: 0 pulse of w us after pre us, 1 no echo, 2 echo held w us (> timeout), 3 stale echo
  task automatic measure(input int kind, input int pre, input int w, input bit drop_en);
    int         ch, n, t, nev;
    int         ev_t [3];
    logic       ev_v [3];
    bit         got, overlap, exp_to;
    int         exp_d;
    logic [1:0] exp_z;
    ch      = exp_ch;
    overlap = 1'b0;
    n = 0;
    while (trig == '0 && n < 5000) begin
      @(negedge clk50);
      n++;
    end
    chk("trig_start", 32'(trig), 32'(1 << ch));
    chk("active_ch_trig", 32'(active_ch), 32'(ch));
    chk("busy_trig", 32'(busy), 32'd1);
    if (kind == 3) echo[ch] = 1'b1;
    n = 0;
    while (trig != '0 && n < 1000) begin
      if (trig !== N_CH'(1 << ch)) overlap = 1'b1;
      @(negedge clk50);
      n++;
    end
    chk("trig_width", 32'(n), TRIG_US * D);

    nev = 0;
    if (kind == 0 || kind == 2) begin
      ev_t[0] = pre * D;       ev_v[0] = 1'b1;
      ev_t[1] = (pre + w) * D; ev_v[1] = 1'b0;
      nev = 2;
    end else if (kind == 3) begin
      ev_t[0] = 10 * D; ev_v[0] = 1'b0;
      ev_t[1] = 30 * D; ev_v[1] = 1'b1;
      ev_t[2] = 80 * D; ev_v[2] = 1'b0;
      nev = 3;
    end
    t   = 0;
    got = 1'b0;
    while (!got && t < 4000) begin
      if (valid != '0) begin
        got = 1'b1;
      end else begin
        if (trig != '0) overlap = 1'b1;
        for (int i = 0; i < nev; i++) if (ev_t[i] == t) echo[ch] = ev_v[i];
        if (drop_en && nev > 0 && t == ev_t[0] + D) enable = 1'b0;
        @(negedge clk50);
        t++;
      end
    end

    exp_to = (kind == 1 || kind == 2);
    exp_d  = exp_to ? 32'hFFFF : ((kind == 3) ? 50 : w);
    exp_z  = exp_to ? 2'b00 : ref_zone(mz[ch], exp_d);
    chk("valid_seen", 32'(got), 32'd1);
    chk("valid_vec", 32'(valid), 32'(1 << ch));
    chk("timeout_vec", 32'(timeout), exp_to ? 32'(1 << ch) : 32'd0);
    chk("dist", 32'(dist_us[ch*CNT_W +: CNT_W]), 32'(exp_d));
    chk("zone", 32'(zone[2*ch +: 2]), 32'(exp_z));
    chk("active_ch_result", 32'(active_ch), 32'(ch));
    if (kind == 1) chk("wait_timeout_len", 32'(t), TO_US * D);
    chk("trig_exclusive", 32'(overlap), 32'd0);
    mz[ch]   = exp_z;
    echo[ch] = 1'b0;
    exp_ch   = (ch + 1) % N_CH;

    @(negedge clk50);
    chk("valid_one_cycle", 32'(valid), 32'd0);
    n = 1;
    if (!drop_en) begin
      while (trig == '0 && n < GAP_US * D + 100) begin
        @(negedge clk50);
        n++;
      end
      chk("gap_len", 32'(n), GAP_US * D);
    end else begin
      while (n < GAP_US * D - 1) begin
        @(negedge clk50);
        n++;
      end
      chk("busy_gap_end", 32'(busy), 32'd1);
      @(negedge clk50);
      chk("busy_parked", 32'(busy), 32'd0);
      repeat (10) @(negedge clk50);
      chk("idle_no_trig", 32'(trig), 32'd0);
      chk("idle_active_ch", 32'(active_ch), 32'(exp_ch));
      enable = 1'b1;
    end
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b0;
    echo   = '0;
    exp_ch = 0;
    for (int k = 0; k < N_CH; k++) mz[k] = 2'b00;
    repeat (3) @(negedge clk50);
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_dist", 32'(dist_us), 32'd0);
    chk("rst_zone", 32'(zone), 32'd0);
    chk("rst_valid", 32'(valid | timeout), 32'd0);
    chk("rst_active", 32'(active_ch), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    reset  = 1'b0;
    enable = 1'b1;

    measure(0, 20, 30, 1'b0);   // ch0 -> near
    measure(1, 0, 0, 1'b0);     // ch1 no echo
    measure(0, 5, 60, 1'b0);    // ch0 near -> mid
    measure(0, 10, 90, 1'b0);   // ch1 far stays far
    measure(0, 3, 43, 1'b0);    // ch0 mid holds in dead band
    measure(0, 7, 20, 1'b0);    // ch1 far -> near
    measure(0, 2, 34, 1'b0);    // ch0 mid -> near
    measure(2, 3, 400, 1'b0);   // ch1 echo stuck high
    measure(0, 4, 41, 1'b0);    // ch0 near holds
    measure(0, 6, 70, 1'b0);    // ch1 far -> mid
    measure(0, 1, 46, 1'b0);    // ch0 near -> mid
    measure(3, 0, 0, 1'b0);     // ch1 stale echo
    measure(0, 8, 25, 1'b1);    // ch0 with enable dropped mid-measurement
    measure(0, 0, 1, 1'b0);     // ch1 resumes, minimum width

    for (int i = 0; i < 9; i++) begin
      int r;
      r = int'($urandom_range(9, 0));
      if (r == 0)      measure(1, 0, 0, 1'b0);
      else if (r == 1) measure(2, int'($urandom_range(50, 0)), int'($urandom_range(400, 320)), 1'b0);
      else             measure(0, int'($urandom_range(50, 0)), int'($urandom_range(250, 1)), 1'b0);
    end

    // Reset in the middle of a ch1 measurement.
    begin
      int n;
      n = 0;
      while (trig == '0 && n < 5000) begin
        @(negedge clk50);
        n++;
      end
      chk("pre_reset_trig", 32'(trig), 32'(1 << exp_ch));
      n = 0;
      while (trig != '0 && n < 1000) begin
        @(negedge clk50);
        n++;
      end
      repeat (2 * D) @(negedge clk50);
      echo[exp_ch] = 1'b1;
      repeat (20 * D) @(negedge clk50);
      #2 reset = 1'b1;
      #1;
      chk("arst_trig", 32'(trig), 32'd0);
      chk("arst_dist", 32'(dist_us), 32'd0);
      chk("arst_zone", 32'(zone), 32'd0);
      chk("arst_valid", 32'(valid | timeout), 32'd0);
      chk("arst_active", 32'(active_ch), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      echo = '0;
      repeat (3) @(negedge clk50);
      reset = 1'b0;
      exp_ch = 0;
      for (int k = 0; k < N_CH; k++) mz[k] = 2'b00;
      @(negedge clk50);
      chk("post_rst_valid", 32'(valid), 32'd0);
    end
    measure(0, 10, 30, 1'b0);   // ch0 fires first after reset

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ultrasonic_scanner.md
Name: ultrasonic_scanner

Overview:
- Parametrised N-channel HC-SR04 ranging engine. Replaces per-sensor duplicated FSMs with one shared, round-robin FSM.
- Fires one sensor at a time to avoid acoustic crosstalk. Measures echo width in microseconds and quantises it into a hysteretic zone code.
- Publishes per-channel registered results with a valid strobe and a timeout flag. Sits between sensor pins and game/direction logic.

Parameters:
N_CH, 2, number of sensor channels (1..8)
US_DIV, 50, clk50 cycles per microsecond tick
TRIG_US, 10, trigger pulse width in µs
TIMEOUT_US, 25000, max wait for echo rise, and max echo width, in µs
GAP_US, 60000, quiet time after each measurement before next channel fires
CNT_W, 16, width of distance field in µs
THR_NEAR, 1160, near/mid boundary in µs (20 cm)
THR_FAR, 2320, mid/far boundary in µs (40 cm)
HYST_US, 58, hysteresis margin in µs (1 cm)

Ports:
clk50  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous active-high reset
enable  in  1  scanning enable
echo  in  N_CH  raw sensor echo inputs (asynchronous)
trig  out  N_CH  sensor trigger outputs, registered
dist_us  out  N_CH*CNT_W  last echo width per channel in µs; channel k at [k*CNT_W +: CNT_W]
zone  out  N_CH*2  per-channel zone: 01 near, 10 mid, 00 far/none
valid  out  N_CH  one-cycle pulse when channel k result updates
timeout  out  N_CH  one-cycle pulse, coincident with valid, when result was a timeout
active_ch  out  3  channel currently being serviced
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): all outputs 0; dist_us 0; zone 00; active_ch 0; FSM IDLE; prescaler, counters, and synchronisers cleared. trig drops immediately on reset assertion.
- µs tick: free-running prescaler, one-cycle tick every US_DIV clk50 cycles. It is cleared on every FSM state change, so state durations are exact multiples of US_DIV.
- echo synchronised through 2 flops per channel. Only the synced value of echo[active_ch] is used. Other channels are ignored.
- FSM states:
  - IDLE: if enable, go to TRIG.
  - TRIG: trig[active_ch]=1 for exactly TRIG_US*US_DIV cycles, then go to WAIT_ECHO. All other trig bits are 0 at all times.
  - WAIT_ECHO: wait for a rising edge (0→1) of synced echo. An echo already high on entry does not start measurement until it falls and rises again. On rise: go to MEASURE with the µs counter at 0. If TIMEOUT_US ticks elapse first: timeout result, go to GAP.
  - MEASURE: count ticks. On synced echo fall: result = count, go to GAP. If count reaches TIMEOUT_US or 2^CNT_W-1, whichever is smaller: timeout result, go to GAP.
  - GAP: wait GAP_US ticks. Then advance active_ch (N_CH-1 wraps to 0). If enable go to TRIG, else go to IDLE.
- Result write occurs on the cycle of the exit from WAIT_ECHO/MEASURE. valid[active_ch] pulses that same cycle (outputs visible next edge).
  - Normal result: dist_us = count. zone updated per hysteresis.
  - Timeout result: dist_us = all ones, zone = 00, timeout pulses.
- Zone hysteresis, applied to previous zone Z and new distance d:
  - Z=01: stays 01 unless d >= THR_NEAR+HYST_US; then 10, or 00 if d >= THR_FAR+HYST_US.
  - Z=10: goes 01 if d < THR_NEAR-HYST_US; goes 00 if d >= THR_FAR+HYST_US; else stays 10.
  - Z=00: goes 01 if d < THR_NEAR-HYST_US; goes 10 if d < THR_FAR-HYST_US; else stays 00.
  - Initial zone after reset is 00.
- enable deasserted mid-measurement: the current channel completes through GAP, then the FSM parks in IDLE. enable reasserted resumes at the next channel.
- Echo fall in the same cycle as the timeout count: treated as a normal result (echo wins).
- Reset mid-operation: all state is abandoned. No valid is emitted for the interrupted channel.

Test Plan:
- Defaults, echo0 pulse 1000 µs starting 200 µs after trig0 falls → trig0 high 500 cycles; valid[0] pulse; dist_us[0]=1000±1; zone[0]=01; timeout[0]=0.
- Round robin, N_CH=2, enable held → trig0 and trig1 alternate, never high together; active_ch toggles 0,1,0 after each GAP of 60000 µs.
- Hysteresis on ch0: widths 1500, 1140, 1090 → zone 10, 10, 01. Then widths 1200, 1220 → zone 01, 10.
- No echo on ch1 → after 25000 µs in WAIT_ECHO, valid[1] and timeout[1] pulse; dist_us[1]=0xFFFF; zone[1]=00. Echo held high 30000 µs gives the same result.
- Stale echo: echo0 already high when WAIT_ECHO is entered, falls at 100 µs, rises at 300 µs, falls at 800 µs → dist_us[0]=500.
- Reset asserted while in MEASURE → trig=0 and all outputs 0 asynchronously; no valid pulse; after release with enable=1, channel 0 is triggered first.
